// File: rtl/graph_mem_arbiter.sv
// Round-robin arbiter sharing one graph-memory read port among NUM_PROC PEs.
// Tags each read with its requester id and routes the data back after READ_LATENCY.
module graph_mem_arbiter #(
   parameter int PROC_BITS    = 2,
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 2
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           hold_in,
   input  logic [(2**PROC_BITS)-1:0]      req_valid_in,
   input  logic [(2**PROC_BITS)*ADDR_W-1:0] req_addr_in,
   output logic [(2**PROC_BITS)-1:0]      req_ready_out,
   output logic [ADDR_W-1:0]              mem_addr_out,
   output logic                           mem_en_out,
   input  logic [DATA_W-1:0]              mem_data_in,
   output logic [(2**PROC_BITS)-1:0]      resp_valid_out,
   output logic [PROC_BITS-1:0]           resp_id_out,
   output logic [DATA_W-1:0]              resp_data_out,
   output logic [PROC_BITS+1:0]           inflight_out
);

   localparam int NUM_PROC = 2**PROC_BITS;
   localparam int LAST     = READ_LATENCY - 1;

   logic [PROC_BITS-1:0] ptr_q, ptr_d;
   logic                 gnt_vld;
   logic [PROC_BITS-1:0] gnt_id;
   logic [PROC_BITS-1:0] cand;

   logic [READ_LATENCY-1:0] tag_vld_q;
   logic [PROC_BITS-1:0]    tag_id_q [READ_LATENCY];

   logic [PROC_BITS+1:0] inflight_q, inflight_d;
   logic                 ret;

   // Pick the first valid requester at or after the round-robin pointer.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      if (rst_in && !hold_in) begin
         for (int k = 0; k < NUM_PROC; k++) begin
            cand = ptr_q + PROC_BITS'(k);
            if (!gnt_vld && req_valid_in[cand]) begin
               gnt_vld = 1'b1;
               gnt_id  = cand;
            end
         end
      end
   end

   // Drive the one-hot grant and the shared memory port.
   always_comb begin
      req_ready_out = '0;
      mem_addr_out  = '0;
      mem_en_out    = gnt_vld;
      if (gnt_vld) begin
         req_ready_out[gnt_id] = 1'b1;
         mem_addr_out = req_addr_in[gnt_id*ADDR_W +: ADDR_W];
      end
   end

   // Next pointer lands just past the winner so it goes last next round.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_vld) begin
         ptr_d = gnt_id + PROC_BITS'(1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Tag pipeline shadows the BRAM latency; ids only move with a valid tag
   // so the final-stage id holds the last delivered requester.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         tag_vld_q <= '0;
         for (int k = 0; k < READ_LATENCY; k++) begin
            tag_id_q[k] <= '0;
         end
      end else begin
         tag_vld_q[0] <= gnt_vld;
         if (gnt_vld) begin
            tag_id_q[0] <= gnt_id;
         end
         for (int k = 1; k < READ_LATENCY; k++) begin
            tag_vld_q[k] <= tag_vld_q[k-1];
            if (tag_vld_q[k-1]) begin
               tag_id_q[k] <= tag_id_q[k-1];
            end
         end
      end
   end

   assign ret = tag_vld_q[LAST];

   // Outstanding-read count: up on issue, down on return.
   always_comb begin
      unique case ({gnt_vld, ret})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   // Outstanding-read counter register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         inflight_q <= '0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   // Decode the returning tag into the per-requester strobe.
   always_comb begin
      resp_valid_out = '0;
      if (ret) begin
         resp_valid_out[tag_id_q[LAST]] = 1'b1;
      end
   end

   assign resp_id_out   = tag_id_q[LAST];
   assign resp_data_out = mem_data_in;
   assign inflight_out  = inflight_q;

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Bench for graph_mem_arbiter: directed test-plan scenarios with literal
// expectations, then random traffic, all compared against a queue model.
module tb_graph_mem_arbiter;

   localparam int PB = 2;
   localparam int N  = 4;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          hold;
   logic [N-1:0]  req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]  req_ready;
   logic [AW-1:0] mem_addr;
   logic          mem_en;
   logic [DW-1:0] mem_data;
   logic [N-1:0]  resp_valid;
   logic [PB-1:0] resp_id;
   logic [DW-1:0] resp_data;
   logic [PB+1:0] inflight;

   int checks = 0;
   int errors = 0;

   graph_mem_arbiter #(
      .PROC_BITS(PB), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)
   ) dut (
      .clk_in(clk), .rst_in(rst_n), .hold_in(hold),
      .req_valid_in(req_valid), .req_addr_in(req_addr),
      .req_ready_out(req_ready), .mem_addr_out(mem_addr),
      .mem_en_out(mem_en), .mem_data_in(mem_data),
      .resp_valid_out(resp_valid), .resp_id_out(resp_id),
      .resp_data_out(resp_data), .inflight_out(inflight)
   );

   always #5 clk = ~clk;

   // Two-stage registered BRAM read model.
   logic [DW-1:0] mem [1024];
   logic [DW-1:0] rd1, rd2;
   always @(posedge clk) begin
      rd1 <= mem[mem_addr];
      rd2 <= rd1;
   end
   assign mem_data = rd2;

   // Reference model: pointer, queue of outstanding reads with due cycle.
   typedef struct {
      int due;
      int id;
      int addr;
   } ent_t;
   ent_t pend[$];
   int   mptr = 0;
   int   last_id = 0;
   int   cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h",
                  nm, cyc, act, exp);
      end
   endtask

   function automatic int model_gnt();
      if (!rst_n || hold) return -1;
      for (int k = 0; k < N; k++) begin
         if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
      end
      return -1;
   endfunction

   always @(negedge rst_n) begin
      pend.delete();
      mptr = 0;
      last_id = 0;
   end

   always @(posedge clk) begin
      int g;
      if (rst_n) begin
         g = model_gnt();
         foreach (pend[i]) if (pend[i].due == cyc) last_id = pend[i].id;
         if (g >= 0) begin
            pend.push_back('{cyc + RL, g, int'(req_addr[g*AW +: AW])});
            mptr = (g + 1) % N;
         end
      end
      cyc++;
      while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
   end

   // Compare process: every cycle, away from the clock edge.
   always @(negedge clk) begin
      int g;
      int ri;
      int cnt;
      logic [N-1:0] er;
      logic [AW-1:0] ea;
      g = model_gnt();
      er = '0;
      ea = '0;
      if (g >= 0) begin
         er[g] = 1'b1;
         ea = req_addr[g*AW +: AW];
      end
      ri = -1;
      cnt = 0;
      foreach (pend[i]) begin
         if (pend[i].due == cyc) ri = i;
         if (pend[i].due >= cyc) cnt++;
      end
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("mem_en", 64'(mem_en), 64'(g >= 0));
      chk("mem_addr", 64'(mem_addr), 64'(ea));
      chk("inflight", 64'(inflight), 64'(cnt));
      if (ri >= 0) begin
         chk("resp_valid", 64'(resp_valid), 64'(1 << pend[ri].id));
         chk("resp_id", 64'(resp_id), 64'(pend[ri].id));
         chk("resp_data", 64'(resp_data), 64'(mem[pend[ri].addr]));
      end else begin
         chk("resp_valid", 64'(resp_valid), 64'(0));
         chk("resp_id_hold", 64'(resp_id), 64'(last_id));
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] v, input logic h);
      req_valid = v;
      hold = h;
   endtask

   task automatic set_addr(input int i, input int a);
      req_addr[i*AW +: AW] = AW'(a);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      nxt();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      for (int i = 0; i < 5; i++) mem[i] = 32'hA000_0000 + i;
      mem[5] = 32'hDEAD_BEEF;
      rst_n = 1'b0;
      drive('0, 1'b0);
      req_addr = '0;

      // Reset state
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 0);
      chk("rst_en", 64'(mem_en), 0);
      chk("rst_resp_valid", 64'(resp_valid), 0);
      chk("rst_resp_id", 64'(resp_id), 0);
      chk("rst_inflight", 64'(inflight), 0);
      nxt();
      rst_n = 1'b1;

      // Single request
      set_addr(2, 5);
      drive(4'b0100, 1'b0);
      @(negedge clk);
      chk("single_ready", 64'(req_ready), 64'h4);
      chk("single_addr", 64'(mem_addr), 64'h5);
      nxt();
      drive('0, 1'b0);
      @(negedge clk);
      chk("single_inflight1", 64'(inflight), 1);
      nxt();
      @(negedge clk);
      chk("single_resp_valid", 64'(resp_valid), 64'h4);
      chk("single_resp_id", 64'(resp_id), 2);
      chk("single_resp_data", 64'(resp_data), 64'hDEAD_BEEF);
      nxt();
      @(negedge clk);
      chk("single_inflight0", 64'(inflight), 0);
      nxt();

      // Fairness from reset
      do_reset();
      for (int i = 0; i < N; i++) set_addr(i, 16 + i);
      drive(4'hF, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("fair_grant", 64'(req_ready), 64'(1 << (i % 4)));
         if (i >= 2) begin
            chk("fair_inflight", 64'(inflight), 2);
            chk("fair_resp_id", 64'(resp_id), 64'((i - 2) % 4));
         end
         nxt();
      end
      drive('0, 1'b0);
      nxt();
      nxt();

      // Wrap and skip: move pointer to 3 first
      drive(4'b0100, 1'b0);
      nxt();
      drive(4'b0011, 1'b0);
      @(negedge clk);
      chk("wrap_g0", 64'(req_ready), 64'h1);
      nxt();
      @(negedge clk);
      chk("wrap_g1", 64'(req_ready), 64'h2);
      nxt();
      @(negedge clk);
      chk("wrap_g2", 64'(req_ready), 64'h1);
      nxt();
      drive('0, 1'b0);
      nxt();
      nxt();

      // Hold in cycles 3-5, pointer is 1 here
      drive(4'hF, 1'b0);
      @(negedge clk);
      chk("hold_c1", 64'(req_ready), 64'h2);
      nxt();
      @(negedge clk);
      chk("hold_c2", 64'(req_ready), 64'h4);
      nxt();
      hold = 1'b1;
      for (int c = 3; c <= 5; c++) begin
         @(negedge clk);
         chk("hold_ready", 64'(req_ready), 0);
         chk("hold_en", 64'(mem_en), 0);
         if (c == 3) chk("hold_resp3", 64'(resp_valid), 64'h2);
         if (c == 4) chk("hold_resp4", 64'(resp_valid), 64'h4);
         nxt();
      end
      hold = 1'b0;
      @(negedge clk);
      chk("hold_resume", 64'(req_ready), 64'h8);
      nxt();
      drive('0, 1'b0);
      nxt();
      nxt();
      nxt();

      // Async reset with a read in flight
      drive(4'b0010, 1'b0);
      @(negedge clk);
      chk("rstmid_grant", 64'(req_ready), 64'h2);
      nxt();
      drive('0, 1'b0);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid_resp1", 64'(resp_valid), 0);
      chk("rstmid_inflight", 64'(inflight), 0);
      nxt();
      @(negedge clk);
      chk("rstmid_resp2", 64'(resp_valid), 0);
      nxt();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid_resp3", 64'(resp_valid), 0);
      nxt();
      @(negedge clk);
      chk("rstmid_resp4", 64'(resp_valid), 0);
      nxt();
      drive(4'hF, 1'b0);
      @(negedge clk);
      chk("rstmid_first", 64'(req_ready), 64'h1);
      nxt();
      drive('0, 1'b0);
      nxt();
      nxt();
      nxt();

      // Single-requester streaming
      drive(4'b1000, 1'b0);
      for (int i = 0; i < 7; i++) begin
         if (i == 5) drive('0, 1'b0);
         if (i < 5) set_addr(3, i);
         @(negedge clk);
         if (i < 5) chk("stream_grant", 64'(req_ready), 64'h8);
         if (i >= 2) begin
            chk("stream_valid", 64'(resp_valid), 64'h8);
            chk("stream_id", 64'(resp_id), 3);
            chk("stream_data", 64'(resp_data), 64'(32'hA000_0000 + i - 2));
         end
         nxt();
      end
      nxt();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            req_valid = N'($urandom);
            hold = ($urandom_range(0, 4) == 0);
            req_addr = {$urandom, $urandom};
            nxt();
         end
      end
      drive('0, 1'b0);
      repeat (4) nxt();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
